umem_ctrl: RTL and testbench
============================

Name: umem_ctrl

Overview:
Parametrised unified memory controller that replaces the separate instruction and data memories with one shared word array. It serves a CPU fetch port and a CPU data port through a single arbitrated access path, with a configurable number of wait states and byte-lane writes. It raises a stall to the core while any request is outstanding, so the single-cycle core can run against slower, realistic memory timing.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 32, byte-address width of both ports.
DEPTH_WORDS, 256, number of words in the array; power of two.
WAIT_STATES, 1, extra cycles per access; 0 to 15.
INIT_FILE, "", hex image loaded with $readmemh at time zero; no load if empty.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
i_req  in  1  fetch request; level, held until i_ready.
i_addr  in  ADDR_W  fetch byte address.
i_ready  out  1  one-cycle pulse; fetch complete.
i_rdata  out  DATA_W  fetched word; valid from the i_ready cycle, held until the next fetch completes.
d_req  in  1  data request; level, held until d_ready.
d_we  in  1  1 = write, 0 = read.
d_be  in  DATA_W/8  byte-lane write enables; ignored on reads.
d_addr  in  ADDR_W  data byte address.
d_wdata  in  DATA_W  write data.
d_ready  out  1  one-cycle pulse; data access complete.
d_rdata  out  DATA_W  read word; valid from the d_ready cycle, held until the next data read completes.
stall  out  1  combinational: (i_req & ~i_ready) | (d_req & ~d_ready).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, grant=none, i_ready=d_ready=0, i_rdata=d_rdata=0. The array is not cleared.
- Word index = addr[2+log2(DEPTH_WORDS)-1:2]. addr[1:0] is ignored. Upper bits wrap modulo DEPTH_WORDS (default build).
- FSM states are IDLE, BUSY and DONE.
- IDLE: if d_req is high, grant D. Otherwise if i_req is high, grant I. Otherwise stay in IDLE.
  - On a grant: latch addr, we, be and wdata; cnt=WAIT_STATES; go to BUSY.
  - When both requests are high in the same cycle, D wins and I waits in IDLE.
- BUSY with cnt>0: decrement cnt.
- BUSY with cnt==0, on that edge:
  - Write: commit the enabled byte lanes.
  - Read: load the addressed word into the granted port's rdata register.
  - Set the granted port's ready to 1 and go to DONE.
- DONE: ready is high for exactly this cycle. Requests are not sampled. Next state is IDLE with ready=0.
- Latency: request asserted in cycle 0 while IDLE gives ready in cycle WAIT_STATES+2. Throughput is one access per WAIT_STATES+3 cycles.
- Master rule: the master drops or changes req only in the cycle its ready is high.
- A write with d_be=0 completes normally and changes no data.
- d_rdata does not change on writes.
- Reset during BUSY aborts the access: no array write, no ready. Reset on the commit edge itself takes precedence, so no write occurs.
- Inputs are latched at grant. Changes to addr or data during BUSY are ignored.

Optional Feature:
Macro MEM_BOUNDS_CHK_EN.
- Defined:
  - An extra output port err (1 bit, reset 0) pulses together with i_ready or d_ready when the latched word index, taken from the full address, is >= DEPTH_WORDS.
  - On such an access, a write is suppressed and a read returns 0.
- Undefined: the err port is absent and addresses wrap as above.

Test Plan:
- WAIT_STATES=1; write d_addr=0x10, d_wdata=0xDEADBEEF, d_be=4'hF at cycle 0 -> d_ready pulse in cycle 3, stall high in cycles 0-2. A following read of 0x10 returns 0xDEADBEEF.
- Byte lanes: word 0x10=0xDEADBEEF, write 0x000000AA with d_be=4'b0001 -> a subsequent read returns 0xDEADBEAA.
- i_req and d_req rise together (i_addr=0x0, d_addr=0x20) -> d_ready in cycle 3, then i_ready in cycle 7. i_rdata=word 0, d_rdata=word 8.
- Wrap (default build): DEPTH_WORDS=256; write 0x55 to d_addr=0x400 -> a read of d_addr=0x000 returns 0x55. With MEM_BOUNDS_CHK_EN: err pulses, word 0 is unchanged, and a read of 0x400 returns 0 with err high.
- Drive reset=0 mid-BUSY on a write to 0x30 -> ready stays 0, word 0x30 is unchanged, outputs are 0. After release, a new request completes with normal latency.
- WAIT_STATES=0; eight back-to-back fetches -> each i_ready comes 2 cycles after its grant, data matches the INIT_FILE image.

Source files
------------

// File: rtl/umem_ctrl.sv
// Unified instruction/data memory controller.
// One word array shared by a fetch port (i_*) and a data port (d_*). A single
// access path is arbitrated between them, with the data port taking priority.
// Each access takes WAIT_STATES extra cycles. Writes are byte-lane masked.
// Optional build macro: MEM_BOUNDS_CHK_EN adds the err output. When it is set,
// accesses whose full word index is >= DEPTH_WORDS pulse err, do not write, and
// read back 0. When it is not set, addresses wrap modulo DEPTH_WORDS.
//
// state | meaning
// IDLE  | no access in flight; sample d_req first, then i_req
// BUSY  | access granted; count down the wait states, then commit
// DONE  | ready pulse cycle; requests are ignored here

module umem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ready,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_rdata,
`ifdef MEM_BOUNDS_CHK_EN
  output logic                  err,
`endif
  output logic                  stall
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

  state_t state, state_nxt;
  grant_t grant;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic              oob;

  logic grant_d_now, grant_i_now, commit;
  logic i_oob, d_oob;
  logic mem_we;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Out-of-range detection uses the address bits above the wrapped index.
`ifdef MEM_BOUNDS_CHK_EN
  assign i_oob = |i_addr[ADDR_W-1:IDX_W+2];
  assign d_oob = |d_addr[ADDR_W-1:IDX_W+2];
`else
  assign i_oob = 1'b0;
  assign d_oob = 1'b0;
`endif

  // Byte offset is never used; upper bits only matter for the bounds check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0],
                              i_addr[ADDR_W-1:IDX_W+2], d_addr[ADDR_W-1:IDX_W+2]};

  assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, arbitration (data port wins) and commit strobe.
  always_comb begin
    state_nxt   = state;
    grant_d_now = 1'b0;
    grant_i_now = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          grant_d_now = 1'b1;
          state_nxt   = BUSY;
        end else if (i_req) begin
          grant_i_now = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_word = oob ? '0 : mem[idx];

  // Request latch, wait-state counter, ready pulses and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant   <= GNT_NONE;
      cnt     <= 4'd0;
      idx     <= '0;
      we      <= 1'b0;
      be      <= '0;
      wdata   <= '0;
      oob     <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_d_now) begin
        grant <= GNT_D;
        idx   <= d_addr[IDX_W+1:2];
        we    <= d_we;
        be    <= d_be;
        wdata <= d_wdata;
        oob   <= d_oob;
        cnt   <= WAIT_CNT;
      end else if (grant_i_now) begin
        grant <= GNT_I;
        idx   <= i_addr[IDX_W+1:2];
        we    <= 1'b0;
        be    <= '0;
        wdata <= '0;
        oob   <= i_oob;
        cnt   <= WAIT_CNT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        if (grant == GNT_D) begin
          d_ready <= 1'b1;
          if (!we) d_rdata <= rd_word;
        end else if (grant == GNT_I) begin
          i_ready <= 1'b1;
          i_rdata <= rd_word;
        end
      end
      if (state == DONE) grant <= GNT_NONE;
    end
  end

`ifdef MEM_BOUNDS_CHK_EN
  // Error pulse coincides with the ready pulse of an out-of-range access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else        err <= commit & oob;
  end
`endif

  // Reset level gates the write so a reset landing on the commit edge wins.
  assign mem_we = reset & commit & (grant == GNT_D) & we & ~oob;

  // Byte-lane masked array write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_umem_ctrl.sv
// Bench for umem_ctrl: directed accesses push expected responses into per-port
// queues; a negedge monitor pops and checks whenever a ready pulse appears.

module tb_umem_ctrl;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        stall;
`ifdef MEM_BOUNDS_CHK_EN
  logic        err;
`endif

  umem_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_STATES(WS), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
`ifdef MEM_BOUNDS_CHK_EN
    .err(err),
`endif
    .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int compared = 0;
  int mismatched = 0;
  logic [31:0] last_d = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (d_ready) begin
        if (dq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL d_unexpected: d_ready at cycle %0d, expected none", cyc);
        end else begin
          e = dq.pop_front();
          chk("d_cycle", 32'(cyc), 32'(e.cyc));
          chk("d_rdata", d_rdata, e.data);
`ifdef MEM_BOUNDS_CHK_EN
          chk("d_err", {31'b0, err}, {31'b0, e.err});
`endif
        end
      end
      if (i_ready) begin
        if (iq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL i_unexpected: i_ready at cycle %0d, expected none", cyc);
        end else begin
          e = iq.pop_front();
          chk("i_cycle", 32'(cyc), 32'(e.cyc));
          chk("i_rdata", i_rdata, e.data);
`ifdef MEM_BOUNDS_CHK_EN
          chk("i_err", {31'b0, err}, {31'b0, e.err});
`endif
        end
      end
    end
  end

  // Data access issued in an IDLE cycle; returns in the following IDLE cycle.
  task automatic d_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd_exp,
                          input logic err_exp);
    exp_t e;
    bit   done = 0;
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    if (!we) last_d = rd_exp;
    e.cyc = cyc + WS + 2; e.data = last_d; e.err = err_exp;
    dq.push_back(e);
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      chk("d_stall", {31'b0, stall}, 32'h1);
      @(posedge clk); #1;
      if (n == 0) begin
        d_addr = 32'hFFFF_FFFC; d_wdata = 32'h5A5A_5A5A; d_be = ~be;
      end
      if (d_ready) done = 1;
    end
    if (!done) begin
      mismatched++;
      $display("FAIL d_timeout: no d_ready for addr %h", addr);
    end
    d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic i_access(input logic [31:0] addr, input logic [31:0] exp_data, input int lat);
    exp_t e;
    bit   done = 0;
    i_req = 1'b1; i_addr = addr;
    e.cyc = cyc + lat; e.data = exp_data; e.err = 1'b0;
    iq.push_back(e);
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      chk("i_stall", {31'b0, stall}, 32'h1);
      @(posedge clk); #1;
      if (i_ready) done = 1;
    end
    if (!done) begin
      mismatched++;
      $display("FAIL i_timeout: no i_ready for addr %h", addr);
    end
    i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Back-to-back fetches: the next address is presented in each ready cycle.
  task automatic i_burst(input logic [31:0] base, input int count, input logic [31:0] dbase);
    exp_t e;
    int   expc;
    bit   done;
    i_req = 1'b1;
    expc = cyc + WS + 2;
    for (int k = 0; k < count; k++) begin
      i_addr = base + 32'(4 * k);
      e.cyc = expc; e.data = dbase + 32'(k); e.err = 1'b0;
      iq.push_back(e);
      done = 0;
      for (int n = 0; n < 40 && !done; n++) begin
        @(posedge clk); #1;
        if (i_ready) done = 1;
      end
      if (!done) begin
        mismatched++;
        $display("FAIL burst_timeout: fetch %0d never completed", k);
      end
      expc = expc + WS + 3;
    end
    i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ready", {31'b0, i_ready}, 32'h0);
    chk("rst_d_ready", {31'b0, d_ready}, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_stall",   {31'b0, stall}, 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Full write, read back, byte lane, empty mask, ignored byte offset.
    d_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    d_access(1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    d_access(1'b1, 4'h1, 32'h10, 32'h000000AA, 32'h0, 1'b0);
    d_access(1'b0, 4'h0, 32'h10, 32'h0,        32'hDEADBEAA, 1'b0);
    d_access(1'b1, 4'h0, 32'h10, 32'h12345678, 32'h0, 1'b0);
    d_access(1'b0, 4'hF, 32'h13, 32'h0,        32'hDEADBEAA, 1'b0);

    // Simultaneous requests: data first, fetch waits one full access.
    d_access(1'b1, 4'hF, 32'h00, 32'h11111111, 32'h0, 1'b0);
    d_access(1'b1, 4'hF, 32'h20, 32'h88888888, 32'h0, 1'b0);
    fork
      d_access(1'b0, 4'hF, 32'h20, 32'h0, 32'h88888888, 1'b0);
      i_access(32'h0, 32'h11111111, 2 * WS + 5);
    join

    // Address beyond the array.
`ifdef MEM_BOUNDS_CHK_EN
    d_access(1'b1, 4'hF, 32'h400, 32'h55, 32'h0, 1'b1);
    d_access(1'b0, 4'hF, 32'h000, 32'h0,  32'h11111111, 1'b0);
    d_access(1'b0, 4'hF, 32'h400, 32'h0,  32'h0, 1'b1);
`else
    d_access(1'b1, 4'hF, 32'h400, 32'h55, 32'h0, 1'b0);
    d_access(1'b0, 4'hF, 32'h000, 32'h0,  32'h55, 1'b0);
`endif

    // Reset in the middle of a write aborts it.
    d_access(1'b1, 4'hF, 32'h30, 32'h30303030, 32'h0, 1'b0);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    d_req = 1'b0;
    chk("abort_d_ready", {31'b0, d_ready}, 32'h0);
    chk("abort_i_ready", {31'b0, i_ready}, 32'h0);
    chk("abort_d_rdata", d_rdata, 32'h0);
    chk("abort_i_rdata", i_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_d_ready_hold", {31'b0, d_ready}, 32'h0);
    @(negedge clk) reset = 1'b1;
    last_d = 32'h0;
    @(posedge clk); #1;
    d_access(1'b0, 4'hF, 32'h30, 32'h0, 32'h30303030, 1'b0);

    // Back-to-back fetch burst over freshly written words.
    for (int k = 0; k < 8; k++)
      d_access(1'b1, 4'hF, 32'h100 + 32'(4 * k), 32'hA0000000 + 32'(k), 32'h0, 1'b0);
    i_burst(32'h100, 8, 32'hA0000000);
    i_access(32'h102, 32'hA0000000, WS + 2);

    repeat (4) @(posedge clk);
    #1;
    chk("d_queue_empty", 32'(dq.size()), 32'h0);
    chk("i_queue_empty", 32'(iq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
